// File: rtl/jtag_host_driver.sv
// jtag_host_driver
//   Command-driven JTAG host. It accepts one command at a time (TAP reset,
//   IR shift, DR shift, idle clocks) and bit-bangs TCK/TMS/TDI. It mirrors the
//   target TAP state and returns one response per command with the captured TDO.
//   After reset it drives a TAP-reset sequence on its own and issues no response.
//
//   Parameter CLK_DIV : TCK half-period in system clocks (1..255).
//   Optional macro JTAG_HOST_TRST_EN : adds io_trst_n. It is low during reset,
//   during the post-reset sequence and during every TAP-reset command.
//
//   Ports
//     clock, reset            system clock, asynchronous active-high reset
//     io_cmd_valid/ready      command handshake
//     io_cmd_op/len/data      command: op (0 rst, 1 IR, 2 DR, 3 idle), length, TDI bits
//     io_rsp_valid/ready      response handshake
//     io_rsp_data/err         captured TDO (bit i = i-th shifted bit) / reject flag
//     io_tck/io_tms/io_tdi    JTAG outputs, io_tdo JTAG input
//     io_tapState            mirrored TAP state
module jtag_host_driver #(
  parameter int CLK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [1:0]  io_cmd_op,
  input  logic [5:0]  io_cmd_len,
  input  logic [31:0] io_cmd_data,
  output logic        io_rsp_valid,
  input  logic        io_rsp_ready,
  output logic [31:0] io_rsp_data,
  output logic        io_rsp_err,
  output logic        io_tck,
  output logic        io_tms,
  output logic        io_tdi,
  input  logic        io_tdo,
  output logic [3:0]  io_tapState
`ifdef JTAG_HOST_TRST_EN
  ,
  output logic        io_trst_n
`endif
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // IEEE 1149.1 TAP transition using this block's state encoding.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    case (s)
      4'h0: n = tms ? 4'h5 : 4'h2;
      4'h1: n = tms ? 4'h5 : 4'h3;
      4'h2: n = tms ? 4'h1 : 4'h2;
      4'h3: n = tms ? 4'h0 : 4'h3;
      4'h4: n = tms ? 4'hF : 4'hE;
      4'h5: n = tms ? 4'h7 : 4'hC;
      4'h6: n = tms ? 4'h1 : 4'h2;
      4'h7: n = tms ? 4'h4 : 4'h6;
      4'h8: n = tms ? 4'hD : 4'hA;
      4'h9: n = tms ? 4'hD : 4'hB;
      4'hA: n = tms ? 4'h9 : 4'hA;
      4'hB: n = tms ? 4'h8 : 4'hB;
      4'hC: n = tms ? 4'h7 : 4'hC;
      4'hD: n = tms ? 4'h7 : 4'hC;
      4'hE: n = tms ? 4'h9 : 4'hA;
      default: n = tms ? 4'hF : 4'hC;
    endcase
    return n;
  endfunction

  // Plan for TCK number k of a command: {tms, is_shift, shift_index}.
  // Shift ops walk 1,0,0 (DR) or 1,1,0,0 (IR) into Shift, shift len bits with
  // TMS=1 on the last one, then 1,0 back to Run-Test/Idle.
  function automatic logic [6:0] tck_plan(input logic [1:0] op, input logic [5:0] len,
                                          input logic [5:0] k);
    logic       tms;
    logic       shift;
    logic [5:0] idx;
    logic [5:0] pre;
    tms   = 1'b0;
    shift = 1'b0;
    idx   = 6'd0;
    pre   = (op == 2'd1) ? 6'd4 : 6'd3;
    case (op)
      2'd0: tms = (k < 6'd5);
      2'd1, 2'd2: begin
        if (k < pre) begin
          tms = (k == 6'd0) || ((op == 2'd1) && (k == 6'd1));
        end else if (k < pre + len) begin
          shift = 1'b1;
          idx   = k - pre;
          tms   = (idx == len - 6'd1);
        end else begin
          tms = (k == pre + len);
        end
      end
      default: tms = 1'b0;
    endcase
    return {tms, shift, idx[4:0]};
  endfunction

  // Index of the final TCK of an accepted, non-empty command.
  function automatic logic [5:0] last_index(input logic [1:0] op, input logic [5:0] len);
    logic [5:0] r;
    case (op)
      2'd0:    r = 6'd5;
      2'd1:    r = len + 6'd5;
      2'd2:    r = len + 6'd4;
      default: r = len - 6'd1;
    endcase
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  div_r, div_s;
  logic [5:0]  k_r, k_s;
  logic [5:0]  last_r, last_s;
  logic [1:0]  op_r, op_s;
  logic [5:0]  len_r, len_s;
  logic [31:0] data_r, data_s;
  logic        quiet_r, quiet_s;     // post-reset sequence: no response
  logic        tck_r, tck_s, tms_r, tms_s, tdi_r, tdi_s;
  logic [3:0]  tap_r, tap_s;
  logic        ready_r, ready_s, rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s;
  logic [31:0] rsp_data_r, rsp_data_s;
`ifdef JTAG_HOST_TRST_EN
  logic        trst_n_r, trst_n_s;
`endif

  logic [6:0] plan_cmd_s, plan_cur_s, plan_nxt_s;
  logic       reject_s;

  assign plan_cmd_s = tck_plan(io_cmd_op, io_cmd_len, 6'd0);
  assign plan_cur_s = tck_plan(op_r, len_r, k_r);
  assign plan_nxt_s = tck_plan(op_r, len_r, k_r + 6'd1);
  assign reject_s   = ((io_cmd_op == 2'd1) || (io_cmd_op == 2'd2)) &&
                      ((io_cmd_len == 6'd0) || (io_cmd_len > 6'd32));

  // State register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_START;
      div_r       <= 8'd0;
      k_r         <= 6'd0;
      last_r      <= 6'd5;
      op_r        <= 2'd0;
      len_r       <= 6'd0;
      data_r      <= 32'd0;
      quiet_r     <= 1'b1;
      tck_r       <= 1'b0;
      tms_r       <= 1'b1;
      tdi_r       <= 1'b0;
      tap_r       <= 4'hF;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= 32'd0;
`ifdef JTAG_HOST_TRST_EN
      trst_n_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      k_r         <= k_s;
      last_r      <= last_s;
      op_r        <= op_s;
      len_r       <= len_s;
      data_r      <= data_s;
      quiet_r     <= quiet_s;
      tck_r       <= tck_s;
      tms_r       <= tms_s;
      tdi_r       <= tdi_s;
      tap_r       <= tap_s;
      ready_r     <= ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_data_r  <= rsp_data_s;
`ifdef JTAG_HOST_TRST_EN
      trst_n_r    <= trst_n_s;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    k_s         = k_r;
    last_s      = last_r;
    op_s        = op_r;
    len_s       = len_r;
    data_s      = data_r;
    quiet_s     = quiet_r;
    tck_s       = tck_r;
    tms_s       = tms_r;
    tdi_s       = tdi_r;
    tap_s       = tap_r;
    ready_s     = ready_r;
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_data_s  = rsp_data_r;
`ifdef JTAG_HOST_TRST_EN
    trst_n_s    = trst_n_r;
`endif
    case (state_r)
      ST_START: begin
        // Begin the autonomous TAP-reset sequence (op 0 registers hold since reset).
        state_s = ST_LOW;
        div_s   = 8'd0;
        k_s     = 6'd0;
        tms_s   = plan_cur_s[6];
        tdi_s   = 1'b0;
      end
      ST_IDLE: begin
        if (io_cmd_valid) begin
          ready_s    = 1'b0;
          op_s       = io_cmd_op;
          len_s      = io_cmd_len;
          data_s     = io_cmd_data;
          quiet_s    = 1'b0;
          k_s        = 6'd0;
          div_s      = 8'd0;
          rsp_data_s = 32'd0;
          rsp_err_s  = 1'b0;
          last_s     = last_index(io_cmd_op, io_cmd_len);
          if (reject_s) begin
            rsp_err_s   = 1'b1;
            rsp_valid_s = 1'b1;
            state_s     = ST_RESP;
          end else if ((io_cmd_op == 2'd3) && (io_cmd_len == 6'd0)) begin
            rsp_valid_s = 1'b1;
            state_s     = ST_RESP;
          end else begin
            state_s = ST_LOW;
            tms_s   = plan_cmd_s[6];
            tdi_s   = plan_cmd_s[5] & io_cmd_data[plan_cmd_s[4:0]];
`ifdef JTAG_HOST_TRST_EN
            if (io_cmd_op == 2'd0) begin
              trst_n_s = 1'b0;
            end else begin
              trst_n_s = 1'b1;
            end
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (div_r == DIV_LAST) begin
          // Rising TCK edge: target sees TMS/TDI; sample TDO and step the TAP mirror.
          div_s   = 8'd0;
          tck_s   = 1'b1;
          tap_s   = tap_next(tap_r, tms_r);
          state_s = ST_HIGH;
          if (plan_cur_s[5]) begin
            rsp_data_s[plan_cur_s[4:0]] = io_tdo;
          end else begin
            rsp_data_s = rsp_data_r;
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      ST_HIGH: begin
        if (div_r == DIV_LAST) begin
          div_s = 8'd0;
          tck_s = 1'b0;
          if (k_r == last_r) begin
`ifdef JTAG_HOST_TRST_EN
            trst_n_s = 1'b1;
`endif
            if (quiet_r) begin
              ready_s = 1'b1;
              state_s = ST_IDLE;
            end else begin
              rsp_valid_s = 1'b1;
              state_s     = ST_RESP;
            end
          end else begin
            k_s     = k_r + 6'd1;
            state_s = ST_LOW;
            tms_s   = plan_nxt_s[6];
            tdi_s   = plan_nxt_s[5] & data_r[plan_nxt_s[4:0]];
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      ST_RESP: begin
        if (io_rsp_ready) begin
          rsp_valid_s = 1'b0;
          rsp_err_s   = 1'b0;
          rsp_data_s  = 32'd0;
          ready_s     = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_START;
    endcase
  end

  assign io_cmd_ready = ready_r;
  assign io_rsp_valid = rsp_valid_r;
  assign io_rsp_data  = rsp_data_r;
  assign io_rsp_err   = rsp_err_r;
  assign io_tck       = tck_r;
  assign io_tms       = tms_r;
  assign io_tdi       = tdi_r;
  assign io_tapState  = tap_r;
`ifdef JTAG_HOST_TRST_EN
  assign io_trst_n    = trst_n_r;
`endif

endmodule
